// File: rtl/s_axis_cc_adapt_x4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s_axis_cc_adapt_x4_pkg
// Brief    : Shared field offsets, type codes and FSM states for the CC adapter
// Revision : 1.0 - initial release
// ============================================================================
package s_axis_cc_adapt_x4_pkg;

    // Legacy 3DW completion header, absolute bit positions in the 128-bit beat
    localparam int LEG_LEN_LSB     = 0;
    localparam int LEG_ATTR_LSB    = 12;
    localparam int LEG_EP_BIT      = 14;
    localparam int LEG_TC_LSB      = 20;
    localparam int LEG_TYPE_LSB    = 24;
    localparam int LEG_FMT_LSB     = 29;
    localparam int LEG_BYTECNT_LSB = 32;
    localparam int LEG_STATUS_LSB  = 45;
    localparam int LEG_CPLID_LSB   = 48;
    localparam int LEG_LOWADDR_LSB = 64;
    localparam int LEG_TAG_LSB     = 72;
    localparam int LEG_REQID_LSB   = 80;

    // UltraScale CC descriptor, absolute bit positions
    localparam int CC_LOWADDR_LSB  = 0;
    localparam int CC_BYTECNT_LSB  = 16;
    localparam int CC_LOCKED_BIT   = 29;
    localparam int CC_DWCNT_LSB    = 32;
    localparam int CC_STATUS_LSB   = 43;
    localparam int CC_POISON_BIT   = 46;
    localparam int CC_REQID_LSB    = 48;
    localparam int CC_TAG_LSB      = 64;
    localparam int CC_CPLID_LSB    = 72;
    localparam int CC_CIDEN_BIT    = 88;
    localparam int CC_TC_LSB       = 89;
    localparam int CC_ATTR_LSB     = 92;
    localparam int CC_ECRC_BIT     = 95;

    localparam logic [4:0] TYPE_CPL   = 5'b01010;
    localparam logic [4:0] TYPE_CPLLK = 5'b01011;

    typedef enum logic [1:0] {
        ST_SOP  = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } cc_state_e;

    // A legacy byte count of zero encodes the 4096-byte maximum
    function automatic logic [12:0] cc_byte_count(input logic [11:0] i_bc);
        return (i_bc == 12'd0) ? 13'd4096 : {1'b0, i_bc};
    endfunction

    function automatic logic [10:0] cc_dword_count(input logic i_has_data,
                                                   input logic [9:0] i_len);
        logic [10:0] w_cnt;
        if (!i_has_data)
            w_cnt = 11'd0;
        else if (i_len == 10'd0)
            w_cnt = 11'd1024;
        else
            w_cnt = {1'b0, i_len};
        return w_cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_axis_cc_adapt_x4_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : cc_axis_pipe_reg
// Brief    : Single-stage valid/ready output register for the CC adapter
// Revision : 1.0 - initial release
// ============================================================================
module cc_axis_pipe_reg #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = 4,
    parameter int USER_W = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic [USER_W-1:0] i_user,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last,
    output logic [USER_W-1:0] o_user,
    output logic              o_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;
    logic [USER_W-1:0] r_user;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_user  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
            r_user  <= i_user;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Upstream may load whenever the slot is empty or being drained this cycle
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;
    assign o_user  = r_user;

endmodule
`default_nettype wire

// File: rtl/s_axis_cc_adapt_x4.sv
`default_nettype none
// ============================================================================
// Module   : s_axis_cc_adapt_x4
// Brief    : Legacy 3DW completion TLP to UltraScale CC descriptor adapter (x4)
// Revision : 1.0 - initial release
// ============================================================================
module s_axis_cc_adapt_x4
    import s_axis_cc_adapt_x4_pkg::*;
#(
    parameter int   DATA_WIDTH      = 128,
    parameter int   KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter logic COMPLETER_ID_EN = 1'b0
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep,
    input  logic                     s_axis_cc_tlast,
    output logic [3:0]               s_axis_cc_tready,
    input  logic [3:0]               s_axis_cc_tuser,
    input  logic                     s_axis_cc_tvalid,
    output logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a,
    output logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep_a,
    output logic                     s_axis_cc_tlast_a,
    input  logic [3:0]               s_axis_cc_tready_a,
    output logic [32:0]              s_axis_cc_tuser_a,
    output logic                     s_axis_cc_tvalid_a,
    output logic                     drop_pulse
);

    localparam int c_NUM_DW = DATA_WIDTH / 32;

    cc_state_e               r_state;
    cc_state_e               w_state_nxt;
    logic                    r_drop_pulse;
    logic                    w_drop_done;
    logic                    w_load;
    logic                    w_pipe_ready;
    logic                    w_core_ready;
    logic                    w_accept;
    logic                    w_is_cpl;
    logic                    w_has_data;
    logic [DATA_WIDTH-1:0]   w_desc;
    logic [DATA_WIDTH-1:0]   w_beat_data;
    logic [c_NUM_DW-1:0]     w_dw_keep;
    logic [c_NUM_DW-1:0]     w_beat_keep;
    logic [32:0]             w_beat_user;
    logic [4:0]              w_type;
    logic                    w_unused_ok;

    assign w_type     = s_axis_cc_tdata[LEG_TYPE_LSB +: 5];
    assign w_is_cpl   = (w_type == TYPE_CPL) || (w_type == TYPE_CPLLK);
    assign w_has_data = s_axis_cc_tdata[LEG_FMT_LSB + 1];

    assign w_core_ready     = (r_state == ST_DROP) || w_pipe_ready;
    assign w_accept         = s_axis_cc_tvalid && w_core_ready;
    assign s_axis_cc_tready = {4{w_core_ready}};

    generate
        for (genvar gi = 0; gi < c_NUM_DW; gi++) begin : g_keep
            assign w_dw_keep[gi] = s_axis_cc_tkeep[4*gi];
        end
    endgenerate

    // Header fields are remapped in place; the first data DW is already aligned
    always_comb begin
        w_desc = '0;
        w_desc[CC_LOWADDR_LSB +: 7]  = s_axis_cc_tdata[LEG_LOWADDR_LSB +: 7];
        w_desc[CC_BYTECNT_LSB +: 13] = cc_byte_count(s_axis_cc_tdata[LEG_BYTECNT_LSB +: 12]);
        w_desc[CC_LOCKED_BIT]        = (w_type == TYPE_CPLLK);
        w_desc[CC_DWCNT_LSB +: 11]   = cc_dword_count(w_has_data,
                                                      s_axis_cc_tdata[LEG_LEN_LSB +: 10]);
        w_desc[CC_STATUS_LSB +: 3]   = s_axis_cc_tdata[LEG_STATUS_LSB +: 3];
        w_desc[CC_POISON_BIT]        = s_axis_cc_tdata[LEG_EP_BIT] | s_axis_cc_tuser[1];
        w_desc[CC_REQID_LSB +: 16]   = s_axis_cc_tdata[LEG_REQID_LSB +: 16];
        w_desc[CC_TAG_LSB +: 8]      = s_axis_cc_tdata[LEG_TAG_LSB +: 8];
        w_desc[CC_CPLID_LSB +: 16]   = s_axis_cc_tdata[LEG_CPLID_LSB +: 16];
        w_desc[CC_CIDEN_BIT]         = COMPLETER_ID_EN;
        w_desc[CC_TC_LSB +: 3]       = s_axis_cc_tdata[LEG_TC_LSB +: 3];
        w_desc[CC_ATTR_LSB +: 3]     = {1'b0, s_axis_cc_tdata[LEG_ATTR_LSB +: 2]};
        w_desc[CC_ECRC_BIT]          = s_axis_cc_tuser[0];
        w_desc[DATA_WIDTH-1:96]      = s_axis_cc_tdata[DATA_WIDTH-1:96];
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state      <= ST_SOP;
            r_drop_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drop_pulse <= w_drop_done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop_done = 1'b0;
        w_beat_data = s_axis_cc_tdata;
        w_beat_keep = w_dw_keep;
        case (r_state)
            ST_SOP: begin
                if (w_accept) begin
                    if (w_is_cpl) begin
                        w_load      = 1'b1;
                        w_beat_data = w_desc;
                        // A data-less completion is exactly the 3-DW descriptor
                        if (!w_has_data)
                            w_beat_keep = 4'b0111;
                        if (!s_axis_cc_tlast)
                            w_state_nxt = ST_BODY;
                    end else if (s_axis_cc_tlast) begin
                        w_drop_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_BODY: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (s_axis_cc_tlast)
                        w_state_nxt = ST_SOP;
                end
            end
            ST_DROP: begin
                if (w_accept && s_axis_cc_tlast) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = ST_SOP;
                end
            end
            default: w_state_nxt = ST_SOP;
        endcase
    end

    assign w_beat_user = {32'd0, s_axis_cc_tuser[3]};

    cc_axis_pipe_reg #(
        .DATA_W (DATA_WIDTH),
        .KEEP_W (c_NUM_DW),
        .USER_W (33)
    ) u_pipe (
        .clk     (user_clk),
        .rst     (user_reset),
        .i_load  (w_load),
        .i_data  (w_beat_data),
        .i_keep  (w_beat_keep),
        .i_last  (s_axis_cc_tlast),
        .i_user  (w_beat_user),
        .i_ready (s_axis_cc_tready_a[0]),
        .o_valid (s_axis_cc_tvalid_a),
        .o_data  (s_axis_cc_tdata_a),
        .o_keep  (s_axis_cc_tkeep_a),
        .o_last  (s_axis_cc_tlast_a),
        .o_user  (s_axis_cc_tuser_a),
        .o_ready (w_pipe_ready)
    );

    assign drop_pulse = r_drop_pulse;

    // Streaming hint, per-byte keep detail and upper ready bits carry no meaning here
    assign w_unused_ok = &{1'b0, s_axis_cc_tkeep, s_axis_cc_tuser[2], s_axis_cc_tready_a[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_s_axis_cc_adapt_x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_axis_cc_adapt_x4
// Brief    : Scoreboard bench for the CC completion adapter
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_axis_cc_adapt_x4;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
        logic [32:0]  u;
    } beat_t;

    logic         user_clk = 1'b0;
    logic         user_reset;
    logic [127:0] s_axis_cc_tdata;
    logic [15:0]  s_axis_cc_tkeep;
    logic         s_axis_cc_tlast;
    logic [3:0]   s_axis_cc_tready;
    logic [3:0]   s_axis_cc_tuser;
    logic         s_axis_cc_tvalid;
    logic [127:0] s_axis_cc_tdata_a;
    logic [3:0]   s_axis_cc_tkeep_a;
    logic         s_axis_cc_tlast_a;
    logic [3:0]   s_axis_cc_tready_a;
    logic [32:0]  s_axis_cc_tuser_a;
    logic         s_axis_cc_tvalid_a;
    logic         drop_pulse;

    int    total = 0;
    int    bad   = 0;
    int    n_drop = 0;
    beat_t sb[$];
    beat_t none_b = '0;
    beat_t prev_b;
    logic  prev_stall = 1'b0;

    always #5 user_clk = ~user_clk;

    s_axis_cc_adapt_x4 #(
        .DATA_WIDTH      (128),
        .KEEP_WIDTH      (16),
        .COMPLETER_ID_EN (1'b0)
    ) dut (
        .user_clk           (user_clk),
        .user_reset         (user_reset),
        .s_axis_cc_tdata    (s_axis_cc_tdata),
        .s_axis_cc_tkeep    (s_axis_cc_tkeep),
        .s_axis_cc_tlast    (s_axis_cc_tlast),
        .s_axis_cc_tready   (s_axis_cc_tready),
        .s_axis_cc_tuser    (s_axis_cc_tuser),
        .s_axis_cc_tvalid   (s_axis_cc_tvalid),
        .s_axis_cc_tdata_a  (s_axis_cc_tdata_a),
        .s_axis_cc_tkeep_a  (s_axis_cc_tkeep_a),
        .s_axis_cc_tlast_a  (s_axis_cc_tlast_a),
        .s_axis_cc_tready_a (s_axis_cc_tready_a),
        .s_axis_cc_tuser_a  (s_axis_cc_tuser_a),
        .s_axis_cc_tvalid_a (s_axis_cc_tvalid_a),
        .drop_pulse         (drop_pulse)
    );

    function automatic logic [127:0] leg(input logic [2:0] fmt, input logic [4:0] typ,
                                         input logic [2:0] tc, input logic ep,
                                         input logic [1:0] attr, input logic [9:0] len,
                                         input logic [15:0] cplid, input logic [2:0] status,
                                         input logic [11:0] bc, input logic [15:0] reqid,
                                         input logic [7:0] tag, input logic [6:0] la,
                                         input logic [31:0] d3);
        logic [31:0] w0, w1, w2;
        w0 = {fmt, typ, 1'b0, tc, 5'd0, ep, attr, 2'd0, len};
        w1 = {cplid, status, 1'b0, bc};
        w2 = {reqid, tag, 1'b0, la};
        return {d3, w2, w1, w0};
    endfunction

    function automatic beat_t eb(input logic [31:0] dw0, input logic [31:0] dw1,
                                 input logic [31:0] dw2, input logic [31:0] dw3,
                                 input logic [3:0] k, input logic l, input logic u);
        beat_t b;
        b.d = {dw3, dw2, dw1, dw0};
        b.k = k;
        b.l = l;
        b.u = {32'd0, u};
        return b;
    endfunction

    function automatic beat_t eraw(input logic [127:0] d, input logic [3:0] k,
                                   input logic l, input logic u);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        b.u = {32'd0, u};
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops expected beats on every IP-side handshake and checks hold stability
    always @(negedge user_clk) begin
        beat_t cur;
        beat_t e;
        cur = '{d: s_axis_cc_tdata_a, k: s_axis_cc_tkeep_a, l: s_axis_cc_tlast_a,
                u: s_axis_cc_tuser_a};
        if (user_reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (drop_pulse)
                n_drop++;
            if (prev_stall) begin
                total++;
                if (!s_axis_cc_tvalid_a || cur !== prev_b) begin
                    bad++;
                    $display("FAIL hold_stable actual=%h/%0b required=%h/1",
                             cur, s_axis_cc_tvalid_a, prev_b);
                end
            end
            if (s_axis_cc_tvalid_a && s_axis_cc_tready_a[0]) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat actual=%h required=none", cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL beat actual=%h required=%h", cur, e);
                    end
                end
            end
            prev_stall <= s_axis_cc_tvalid_a && !s_axis_cc_tready_a[0];
            prev_b     <= cur;
        end
    end

    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge user_clk);
            if (s_axis_cc_tready[0])
                break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL %s_timeout actual=not_ready required=ready", nm);
                break;
            end
        end
        @(posedge user_clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l,
                        input logic [3:0] u, input bit has_exp, input beat_t e);
        s_axis_cc_tdata  = d;
        s_axis_cc_tkeep  = k;
        s_axis_cc_tlast  = l;
        s_axis_cc_tuser  = u;
        s_axis_cc_tvalid = 1'b1;
        if (has_exp)
            sb.push_back(e);
        wait_accept("send");
    endtask

    task automatic idle(input int n);
        s_axis_cc_tvalid = 1'b0;
        s_axis_cc_tlast  = 1'b0;
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v1;
        beat_t        e1;
        user_reset         = 1'b1;
        s_axis_cc_tdata    = '0;
        s_axis_cc_tkeep    = '0;
        s_axis_cc_tlast    = 1'b0;
        s_axis_cc_tuser    = '0;
        s_axis_cc_tvalid   = 1'b0;
        s_axis_cc_tready_a = 4'hF;
        repeat (2) @(posedge user_clk);
        #1;
        chk("rst_tvalid_a", {31'd0, s_axis_cc_tvalid_a}, 32'd0);
        chk("rst_tdata_a_lo", s_axis_cc_tdata_a[31:0], 32'd0);
        chk("rst_tdata_a_hi", s_axis_cc_tdata_a[127:96], 32'd0);
        chk("rst_tkeep_a", {28'd0, s_axis_cc_tkeep_a}, 32'd0);
        chk("rst_tlast_a", {31'd0, s_axis_cc_tlast_a}, 32'd0);
        chk("rst_tuser_a", s_axis_cc_tuser_a[31:0], 32'd0);
        chk("rst_drop", {31'd0, drop_pulse}, 32'd0);
        user_reset = 1'b0;
        @(posedge user_clk);
        #1;

        v1 = leg(3'b010, 5'b01010, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0200, 3'd0, 12'd4,
                 16'h0100, 8'h2A, 7'h10, 32'hDEADBEEF);
        e1 = eb(32'h00040010, 32'h01000001, 32'h0002002A, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);

        // Back-to-back single-beat completions, including boundary encodings
        send(v1, 16'hFFFF, 1'b1, 4'h0, 1'b1, e1);
        send(leg(3'b000, 5'b01010, 3'd0, 1'b0, 2'd0, 10'd0, 16'hABCD, 3'b010, 12'd0,
                 16'h1234, 8'h05, 7'h00, 32'h11111111), 16'h0FFF, 1'b1, 4'h0, 1'b1,
             eb(32'h10000000, 32'h12341000, 32'h00ABCD05, 32'h11111111, 4'b0111, 1'b1, 1'b0));
        send(leg(3'b010, 5'b01010, 3'b101, 1'b0, 2'b11, 10'd0, 16'h0001, 3'd0, 12'h800,
                 16'hFFFF, 8'hFF, 7'h44, 32'hCAFEF00D), 16'hFFFF, 1'b1, 4'h0, 1'b1,
             eb(32'h08000044, 32'hFFFF0400, 32'h3A0001FF, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0));
        send(leg(3'b000, 5'b01011, 3'd0, 1'b0, 2'd0, 10'd0, 16'h0003, 3'd0, 12'h00C,
                 16'h0002, 8'h10, 7'h08, 32'h0), 16'hFFFF, 1'b1, 4'h0, 1'b1,
             eb(32'h200C0008, 32'h00020000, 32'h00000310, 32'h0, 4'b0111, 1'b1, 1'b0));
        idle(3);

        // 3-beat CplD with the IP stalling the output for 3 cycles
        send(leg(3'b010, 5'b01010, 3'd0, 1'b1, 2'd0, 10'd8, 16'h0C0D, 3'd0, 12'h020,
                 16'h0A0B, 8'h01, 7'h00, 32'h00000001), 16'hFFFF, 1'b0, 4'h0, 1'b1,
             eb(32'h00200000, 32'h0A0B4008, 32'h000C0D01, 32'h00000001, 4'hF, 1'b0, 1'b0));
        send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF, 1'b0, 4'h0, 1'b1,
             eraw(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4'hF, 1'b0, 1'b0));
        s_axis_cc_tready_a = 4'h0;
        s_axis_cc_tdata    = {4{32'hA5A5_5A5A}};
        s_axis_cc_tkeep    = 16'h00FF;
        s_axis_cc_tlast    = 1'b1;
        s_axis_cc_tuser    = 4'b1000;
        sb.push_back(eraw({4{32'hA5A5_5A5A}}, 4'b0011, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge user_clk);
            chk("stall_tready", {28'd0, s_axis_cc_tready}, 32'h0);
            @(posedge user_clk);
            #1;
        end
        s_axis_cc_tready_a = 4'hF;
        wait_accept("stall_beat3");
        idle(3);

        // MWr 3 beats: discarded, ready held high even while the IP stalls
        send({96'd0, 32'h40000001}, 16'hFFFF, 1'b0, 4'h0, 1'b0, none_b);
        s_axis_cc_tready_a = 4'h0;
        s_axis_cc_tdata    = {4{32'h7777_0000}};
        s_axis_cc_tlast    = 1'b0;
        @(negedge user_clk);
        chk("drop_tready_b2", {28'd0, s_axis_cc_tready}, 32'hF);
        chk("drop_no_valid_b2", {31'd0, s_axis_cc_tvalid_a}, 32'd0);
        @(posedge user_clk);
        #1;
        s_axis_cc_tlast = 1'b1;
        @(negedge user_clk);
        chk("drop_tready_b3", {28'd0, s_axis_cc_tready}, 32'hF);
        @(posedge user_clk);
        #1;
        s_axis_cc_tready_a = 4'hF;
        idle(3);
        chk("drop_count_mwr", n_drop, 32'd1);

        // Single-beat MRd-type packet dropped at SOP, then a CplD
        send({96'd0, 32'h00000001}, 16'hFFFF, 1'b1, 4'h0, 1'b0, none_b);
        send(v1, 16'hFFFF, 1'b1, 4'h0, 1'b1, e1);
        idle(3);
        chk("drop_count_mrd", n_drop, 32'd2);

        // Poison/ECRC/discontinue sideband on the SOP beat
        send(v1, 16'hFFFF, 1'b1, 4'b1011, 1'b1,
             eb(32'h00040010, 32'h01004001, 32'h8002002A, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1));
        idle(3);

        // Reset in the middle of a 4-beat CplD
        send(leg(3'b010, 5'b01010, 3'd0, 1'b0, 2'd0, 10'd12, 16'h0001, 3'd0, 12'd48,
                 16'h0002, 8'h33, 7'h00, 32'h55555555), 16'hFFFF, 1'b0, 4'h0, 1'b1,
             eb(32'h00300000, 32'h0002000C, 32'h00000133, 32'h55555555, 4'hF, 1'b0, 1'b0));
        send({4{32'h9999_8888}}, 16'hFFFF, 1'b0, 4'h0, 1'b1,
             eraw({4{32'h9999_8888}}, 4'hF, 1'b0, 1'b0));
        user_reset       = 1'b1;
        s_axis_cc_tvalid = 1'b0;
        #1;
        chk("mid_rst_tvalid_a", {31'd0, s_axis_cc_tvalid_a}, 32'd0);
        sb.delete();
        repeat (2) @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        send(v1, 16'hFFFF, 1'b1, 4'h0, 1'b1, e1);
        idle(5);

        chk("sb_drained", sb.size(), 32'd0);
        chk("drop_count_final", n_drop, 32'd2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
